mux8x1_using_4x1: RTL and testbench
===================================

MUX8X1_USING_4X1 -- requirements
Module: mux8x1_using_4x1

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port `clk` SHALL be an input, 1 bit: rising-edge clock for the registered output.
REQ-004 Port `rst_n` SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-005 Port `Out` SHALL be an output, 1 bit: combinational mux result.
REQ-006 Port `S0` SHALL be an input, 1 bit: select MSB.
REQ-007 Port `S1` SHALL be an input, 1 bit: select middle bit.
REQ-008 Port `S2` SHALL be an input, 1 bit: select LSB.
REQ-009 Port `I` SHALL be an input, 8 bits: data inputs I[7:0].
REQ-010 Port `Out_q` SHALL be an output, 1 bit: registered copy of Out.
REQ-011 Port declaration order SHALL be Out, S0, S1, S2, I, clk, rst_n, Out_q, so that positional instantiations of the form (Out, S0, S1, S2, I) bind correctly.

Function
REQ-012 Select index SHALL be sel = {S0, S1, S2}, with S0 as MSB and S2 as LSB.
REQ-013 Out SHALL equal I[sel] combinationally, with zero clock latency and independent of clk and rst_n.
REQ-014 Out SHALL respond to any change of S0..S2 or I within the same delta/evaluation step; there SHALL be no latch inferred.
REQ-015 Out_q SHALL load Out on every rising clk edge while rst_n=1, giving 1-cycle latency.
REQ-016 If any select or data bit is X/Z in simulation, Out SHALL be X unless all candidate inputs agree; Out_q SHALL capture that value.
REQ-017 Simultaneous change of select and data SHALL yield I_new[sel_new]; no glitch-free guarantee is required on Out.

Reset
REQ-018 Asserting rst_n=0 SHALL force Out_q=0 immediately, asynchronously to clk.
REQ-019 Deassertion SHALL be synchronised by the user; the first rising edge with rst_n=1 SHALL load Out into Out_q.
REQ-020 Reset SHALL NOT affect Out; the combinational path SHALL stay live during reset.
REQ-021 Reset asserted mid-operation SHALL clear Out_q within the same timestep, regardless of clock phase.

Structure
REQ-022 The block SHALL instantiate a sub-module mux4x1 twice:
- lower instance: data I[3:0], select {S1, S2}
- upper instance: data I[7:4], select {S1, S2}
REQ-023 A 2:1 stage selected by S0 SHALL combine the two results: S0=0 selects the lower instance, S0=1 selects the upper instance.
REQ-024 mux4x1 SHALL have ports (out, s_hi, s_lo, in[3:0]) and SHALL compute out = in[{s_hi, s_lo}].
REQ-025 A shared package SHALL hold localparam N_IN=8 and SEL_W=3; no typedefs are needed.
REQ-026 The output register SHALL be the only sequential element in the block.

Verification
REQ-027 The bench SHALL apply a one-hot walk: for k = 0..7, sel=k and I=(1<<k) -> Out=1 at each step, 10-time-unit spacing.
REQ-028 The bench SHALL apply inverse one-hot: for k = 0..7, sel=k and I=~(1<<k) -> Out=0.
REQ-029 The bench SHALL check bit ordering: S0=0, S1=0, S2=1, I=8'h02 -> Out=1; S0=1, S1=0, S2=0, I=8'h10 -> Out=1; S0=1, S1=0, S2=0, I=8'h02 -> Out=0.
REQ-030 The bench SHALL check register latency: sel=7, I=8'h80, then one rising clk edge -> Out_q=1; then I=8'h00 -> Out=0 immediately while Out_q stays 1 until the next edge.
REQ-031 The bench SHALL check asynchronous reset: with Out_q=1, drive rst_n=0 between clock edges -> Out_q=0 at once while Out is unchanged; after release, the next edge reloads Out_q.
REQ-032 The bench SHALL run an exhaustive sweep of all 2048 combinations of {sel, I} -> Out == I[sel] every time.

Source files
------------

// File: rtl/mux8x1_using_4x1_pkg.sv
// Shared sizing constants for the 8:1 mux built from two 4:1 muxes.
package mux8x1_using_4x1_pkg;
  localparam int N_IN  = 8;
  localparam int SEL_W = 3;
endpackage

// File: rtl/mux8x1_using_4x1_mux4x1.sv
// 4:1 mux leaf cell: out = in[{s_hi, s_lo}].
module mux4x1 (
  output logic       out,
  input  logic       s_hi,
  input  logic       s_lo,
  input  logic [3:0] in
);

  // Nested ternaries rather than an indexed select: with an unknown select
  // bit the result only resolves when the candidate inputs agree.
  assign out = s_hi ? (s_lo ? in[3] : in[2])
                    : (s_lo ? in[1] : in[0]);

endmodule

// File: rtl/mux8x1_using_4x1.sv
// 8:1 mux from two 4:1 muxes and a 2:1 stage, plus a registered copy of the result.
module mux8x1_using_4x1
  import mux8x1_using_4x1_pkg::*;
(
  output logic            Out,
  input  logic            S0,
  input  logic            S1,
  input  logic            S2,
  input  logic [N_IN-1:0] I,
  input  logic            clk,
  input  logic            rst_n,
  output logic            Out_q
);

  logic [SEL_W-1:0] sel;
  logic             lo_out;
  logic             hi_out;

  assign sel = {S0, S1, S2};

  mux4x1 u_lo (
    .out  (lo_out),
    .s_hi (sel[1]),
    .s_lo (sel[0]),
    .in   (I[3:0])
  );

  mux4x1 u_hi (
    .out  (hi_out),
    .s_hi (sel[1]),
    .s_lo (sel[0]),
    .in   (I[7:4])
  );

  assign Out = sel[2] ? hi_out : lo_out;

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Out_q <= 1'b0;
    else        Out_q <= Out;
  end

endmodule

// File: tb/tb_mux8x1_using_4x1.sv
// Self-checking bench for mux8x1_using_4x1: vector table, directed register/reset sequences,
// exhaustive sweep and randomized cycles against a bit-extraction reference model.
module tb_mux8x1_using_4x1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       S0, S1, S2;
  logic [7:0] I;
  logic       Out, Out_q;

  int n_cmp = 0;
  int n_err = 0;

  mux8x1_using_4x1 dut (
    .Out   (Out),
    .S0    (S0),
    .S1    (S1),
    .S2    (S2),
    .I     (I),
    .clk   (clk),
    .rst_n (rst_n),
    .Out_q (Out_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] data;
    logic       exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, wanted %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] s, input logic [7:0] d);
    {S0, S1, S2} = s;
    I = d;
  endtask

  // Reference: bit number sel of the data word.
  function automatic logic model(input logic [2:0] s, input logic [7:0] d);
    return logic'((d >> s) & 8'h01);
  endfunction

  initial begin
    logic       exp_q;
    logic [2:0] rs;
    logic [7:0] rd;

    rst_n = 1'b0;
    drive(3'd0, 8'h00);
    #1;
    check("reset_out_q", Out_q, 1'b0);
    check("reset_out_live", Out, 1'b0);
    drive(3'd3, 8'h08);
    #1;
    check("reset_out_live_hi", Out, 1'b1);

    // One-hot walk, inverse one-hot walk, then bit-ordering cases.
    for (int k = 0; k < 8; k++) vecs.push_back('{sel: 3'(k), data: 8'(1 << k), exp: 1'b1});
    for (int k = 0; k < 8; k++) vecs.push_back('{sel: 3'(k), data: ~8'(1 << k), exp: 1'b0});
    vecs.push_back('{sel: 3'b001, data: 8'h02, exp: 1'b1});
    vecs.push_back('{sel: 3'b100, data: 8'h10, exp: 1'b1});
    vecs.push_back('{sel: 3'b100, data: 8'h02, exp: 1'b0});

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].data);
      #10;
      check($sformatf("vec%0d_sel%0d_I%02h", i, vecs[i].sel, vecs[i].data), Out, vecs[i].exp);
    end

    // Release reset between edges; first edge loads Out.
    @(negedge clk);
    rst_n = 1'b1;

    // Register latency.
    @(negedge clk);
    drive(3'd7, 8'h80);
    @(posedge clk); #1;
    check("lat_load", Out_q, 1'b1);
    I = 8'h00;
    #1;
    check("lat_out_immediate", Out, 1'b0);
    check("lat_q_holds", Out_q, 1'b1);
    @(posedge clk); #1;
    check("lat_q_next_edge", Out_q, 1'b0);

    // Asynchronous reset mid-cycle.
    I = 8'h80;
    @(posedge clk); #1;
    check("arst_pre_q", Out_q, 1'b1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_q_clear", Out_q, 1'b0);
    check("arst_out_unchanged", Out, 1'b1);
    @(posedge clk); #1;
    check("arst_q_held", Out_q, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_reload", Out_q, 1'b1);

    // Exhaustive combinational sweep.
    for (int s = 0; s < 8; s++) begin
      for (int d = 0; d < 256; d++) begin
        drive(3'(s), 8'(d));
        #1;
        check($sformatf("sweep_sel%0d_I%02h", s, d), Out, model(3'(s), 8'(d)));
      end
    end

    // Randomized cycles: combinational result and one-cycle-late register.
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rs = 3'($urandom_range(0, 7));
      rd = 8'($urandom);
      drive(rs, rd);
      exp_q = model(rs, rd);
      #1;
      check($sformatf("rand%0d_out", n), Out, exp_q);
      @(posedge clk); #1;
      check($sformatf("rand%0d_q", n), Out_q, exp_q);
      // Change inputs after the edge; register must hold the captured value.
      drive(~rs, ~rd);
      #1;
      check($sformatf("rand%0d_q_hold", n), Out_q, exp_q);
      check($sformatf("rand%0d_out_new", n), Out, model(~rs, ~rd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
